// File: rtl/icache_miss_ctrl.sv
// icache_miss_ctrl: I-cache line refill sequencer between fetch and memory.
// Ports: clk, rst (async active-low); icRE/icReadHit/icReadAddrIn/flush from
//   fetch; memReq* request and memResp* beat channel to the memory arbiter;
//   fillWE/fillAddr/fillData line write to the I-cache array; missBusy stall.
//   Optional missCount output when ICACHE_MISS_PERF_COUNTER_EN is defined.
module icache_miss_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    icRE,
    input  logic                    icReadHit,
    input  logic [ADDR_WIDTH-1:0]   icReadAddrIn,
    input  logic                    flush,
    output logic                    memReqValid,
    input  logic                    memReqReady,
    output logic [ADDR_WIDTH-1:0]   memReqAddr,
    input  logic                    memRespValid,
    input  logic [BEAT_WIDTH-1:0]   memRespData,
    output logic                    fillWE,
    output logic [ADDR_WIDTH-1:0]   fillAddr,
    output logic [LINE_BYTES*8-1:0] fillData,
    output logic                    missBusy
`ifdef ICACHE_MISS_PERF_COUNTER_EN
    ,
    output logic [31:0]             missCount
`endif
);

    localparam int BEATS = LINE_BYTES * 8 / BEAT_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [BW-1:0]         LAST_BEAT = BW'(BEATS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]                           r_state;
    logic [ADDR_WIDTH-1:0]                r_addr;
    logic [BW-1:0]                        r_beat;
    logic                                 r_abort;
    logic [BEATS-1:0][BEAT_WIDTH-1:0]     r_buf;

    logic w_miss;

    assign w_miss = icRE && !icReadHit && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_beat  <= '0;
            r_abort <= 1'b0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_addr  <= icReadAddrIn & ~OFF_MASK;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A flush beats a same-cycle accept: nothing is issued.
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (memReqReady) begin
                        r_beat  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The request is already outstanding, so a flush only
                    // suppresses the final write; all beats are still drained.
                    if (flush) begin
                        r_abort <= 1'b1;
                    end
                    if (memRespValid) begin
                        r_buf[r_beat] <= memRespData;
                        if (r_beat == LAST_BEAT) begin
                            r_beat  <= '0;
                            r_state <= S_WRITE;
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    r_abort <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign memReqValid = (r_state == S_REQ);
    assign memReqAddr  = r_addr;
    assign fillWE      = (r_state == S_WRITE) && !r_abort;
    assign fillAddr    = r_addr;
    assign fillData    = r_buf;
    assign missBusy    = (r_state != S_IDLE);

`ifdef ICACHE_MISS_PERF_COUNTER_EN
    logic [31:0] r_missCount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_missCount <= '0;
        end else if (fillWE) begin
            r_missCount <= r_missCount + 32'd1;
        end
    end

    assign missCount = r_missCount;
`endif

`ifndef SYNTHESIS
    a_no_resp_in_idle: assert property (
        @(posedge clk) disable iff (!rst)
        !((r_state == S_IDLE) && memRespValid)
    ) else $error("memory response beat while idle");
`endif

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// tb_icache_miss_ctrl: table-driven and randomized refill scenarios
// for icache_miss_ctrl, checked against a transaction-level model.
module tb_icache_miss_ctrl;

    logic         clk;
    logic         rst;
    logic         icRE;
    logic         icReadHit;
    logic [31:0]  icReadAddrIn;
    logic         flush;
    logic         memReqValid;
    logic         memReqReady;
    logic [31:0]  memReqAddr;
    logic         memRespValid;
    logic [31:0]  memRespData;
    logic         fillWE;
    logic [31:0]  fillAddr;
    logic [127:0] fillData;
    logic         missBusy;
`ifdef ICACHE_MISS_PERF_COUNTER_EN
    logic [31:0]  missCount;
`endif

    icache_miss_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .icRE         (icRE),
        .icReadHit    (icReadHit),
        .icReadAddrIn (icReadAddrIn),
        .flush        (flush),
        .memReqValid  (memReqValid),
        .memReqReady  (memReqReady),
        .memReqAddr   (memReqAddr),
        .memRespValid (memRespValid),
        .memRespData  (memRespData),
        .fillWE       (fillWE),
        .fillAddr     (fillAddr),
        .fillData     (fillData),
        .missBusy     (missBusy)
`ifdef ICACHE_MISS_PERF_COUNTER_EN
        ,
        .missCount    (missCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One refill scenario: stimulus timing plus expected outcome.
    // fmode: 0 none, 1 flush in REQ at ready-wait cycle fr,
    //        2 flush in WAIT together with beat fb.
    typedef struct {
        logic [31:0]      addr;
        int               d;
        int               g0;
        int               g;
        int               fmode;
        int               fr;
        int               fb;
        bit               mw;
        logic [3:0][31:0] beats;
        logic [31:0]      e_addr;
        int               e_req;
        int               e_fill;
        logic [127:0]     e_line;
        int               e_busy;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    // Monotonic event counters sampled mid-cycle.
    int           m_req  = 0;
    int           m_fill = 0;
    int           m_busy = 0;
    logic [31:0]  m_req_addr  = '0;
    logic [31:0]  m_fill_addr = '0;
    logic [127:0] m_fill_data = '0;

    always @(negedge clk) begin
        if (memReqValid && memReqReady && !flush) begin
            m_req++;
            m_req_addr = memReqAddr;
        end
        if (fillWE) begin
            m_fill++;
            m_fill_addr = fillAddr;
            m_fill_data = fillData;
        end
        if (missBusy) m_busy++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic [31:0] addr, input int d, input int g0, input int g,
        input int fmode, input int fr, input int fb, input bit mw,
        input logic [3:0][31:0] beats, input logic [31:0] e_addr,
        input int e_req, input int e_fill, input logic [127:0] e_line,
        input int e_busy);
        vec_t v;
        v.addr = addr; v.d = d; v.g0 = g0; v.g = g;
        v.fmode = fmode; v.fr = fr; v.fb = fb; v.mw = mw;
        v.beats = beats; v.e_addr = e_addr; v.e_req = e_req;
        v.e_fill = e_fill; v.e_line = e_line; v.e_busy = e_busy;
        return v;
    endfunction

    // Reference model: outcome of a refill from the transaction rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.e_addr = v.addr & ~32'hF;
        if (v.fmode == 1) begin
            r.e_req  = 0;
            r.e_fill = 0;
            r.e_busy = v.fr + 1;
        end else begin
            r.e_req  = 1;
            r.e_fill = (v.fmode == 0) ? 1 : 0;
            r.e_busy = (v.d + 1) + (v.g0 + 3 * v.g + 4) + 1;
        end
        r.e_line = '0;
        for (int k = 0; k < 4; k++) r.e_line[k*32 +: 32] = v.beats[k];
        return r;
    endfunction

    task automatic finish_scn(input vec_t v, input int req0,
                              input int fill0, input int busy0);
        chk("req_count", 128'(m_req - req0), 128'(v.e_req));
        if (v.e_req != 0) chk("req_addr", m_req_addr, v.e_addr);
        chk("fill_count", 128'(m_fill - fill0), 128'(v.e_fill));
        if (v.e_fill != 0) begin
            chk("fill_addr", m_fill_addr, v.e_addr);
            chk("fill_data", m_fill_data, v.e_line);
        end
        chk("busy_cycles", 128'(m_busy - busy0), 128'(v.e_busy));
        if (v.e_fill != 0) exp_cnt++;
`ifdef ICACHE_MISS_PERF_COUNTER_EN
        chk("miss_count", missCount, 128'(exp_cnt));
`endif
    endtask

    task automatic run(input vec_t v);
        int req0  = m_req;
        int fill0 = m_fill;
        int busy0 = m_busy;
        icRE = 1'b1;
        icReadHit = 1'b0;
        icReadAddrIn = v.addr;
        tick;
        icRE = 1'b0;
        icReadAddrIn = '0;
        for (int i = 0; i <= v.d; i++) begin
            if (v.fmode == 1 && i == v.fr) begin
                flush = 1'b1;
                memReqReady = (i == v.d);
                tick;
                flush = 1'b0;
                memReqReady = 1'b0;
                chk("flush_req_idle", missBusy, 1'b0);
                chk("flush_req_valid", memReqValid, 1'b0);
                finish_scn(v, req0, fill0, busy0);
                return;
            end
            memReqReady = (i == v.d);
            if (i < v.d) begin
                chk("req_hold_valid", memReqValid, 1'b1);
                chk("req_hold_addr", memReqAddr, v.e_addr);
            end
            tick;
        end
        memReqReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? v.g0 : v.g) tick;
            memRespValid = 1'b1;
            memRespData = v.beats[k];
            flush = (v.fmode == 2 && k == v.fb);
            tick;
            memRespValid = 1'b0;
            flush = 1'b0;
        end
        if (v.mw) begin
            icRE = 1'b1;
            icReadHit = 1'b0;
            icReadAddrIn = 32'h0000_9990;
        end
        chk("write_busy", missBusy, 1'b1);
        chk("write_we", fillWE, 128'(v.e_fill));
        tick;
        icRE = 1'b0;
        icReadAddrIn = '0;
        chk("after_write_busy", missBusy, 1'b0);
        chk("after_write_req", memReqValid, 1'b0);
        tick;
        chk("no_extra_req", memReqValid, 1'b0);
        finish_scn(v, req0, fill0, busy0);
    endtask

    vec_t tbl[8];

    initial begin
        rst = 1'b0;
        icRE = 1'b0;
        icReadHit = 1'b0;
        icReadAddrIn = '0;
        flush = 1'b0;
        memReqReady = 1'b0;
        memRespValid = 1'b0;
        memRespData = '0;

        tbl[0] = mkv(32'h0000_1234, 0, 1, 0, 0, 0, 0, 1'b0,
                     {32'hD, 32'hC, 32'hB, 32'hA}, 32'h0000_1230, 1, 1,
                     128'h0000000D_0000000C_0000000B_0000000A, 7);
        tbl[1] = mkv(32'h0000_5678, 5, 1, 0, 0, 0, 0, 1'b0,
                     {32'h44, 32'h33, 32'h22, 32'h11}, 32'h0000_5670, 1, 1,
                     128'h00000044_00000033_00000022_00000011, 12);
        tbl[2] = mkv(32'h0000_2004, 0, 1, 0, 2, 0, 2, 1'b0,
                     {32'h4, 32'h3, 32'h2, 32'h1}, 32'h0000_2000, 1, 0,
                     128'h00000004_00000003_00000002_00000001, 7);
        tbl[3] = mkv(32'h0000_0ABC, 3, 1, 0, 1, 1, 0, 1'b0,
                     {32'h0, 32'h0, 32'h0, 32'h0}, 32'h0000_0AB0, 0, 0,
                     128'h0, 2);
        tbl[4] = mkv(32'h0000_0040, 0, 1, 0, 0, 0, 0, 1'b0,
                     {32'h8, 32'h7, 32'h6, 32'h5}, 32'h0000_0040, 1, 1,
                     128'h00000008_00000007_00000006_00000005, 7);
        tbl[5] = mkv(32'h0000_0108, 2, 1, 0, 1, 2, 0, 1'b0,
                     {32'h0, 32'h0, 32'h0, 32'h0}, 32'h0000_0100, 0, 0,
                     128'h0, 3);
        tbl[6] = mkv(32'hDEAD_BEEF, 1, 2, 2, 0, 0, 0, 1'b1,
                     {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001,
                      32'hCAFE_0000}, 32'hDEAD_BEE0, 1, 1,
                     128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 15);
        tbl[7] = mkv(32'hFFFF_FFFF, 0, 3, 1, 2, 0, 3, 1'b0,
                     {32'h9, 32'h9, 32'h9, 32'h9}, 32'hFFFF_FFF0, 1, 0,
                     128'h00000009_00000009_00000009_00000009, 12);

        tick;
        tick;
        chk("rst_req_valid", memReqValid, 1'b0);
        chk("rst_req_addr", memReqAddr, 32'h0);
        chk("rst_fill_we", fillWE, 1'b0);
        chk("rst_fill_data", fillData, 128'h0);
        chk("rst_busy", missBusy, 1'b0);
        rst = 1'b1;
        tick;

        for (int i = 0; i < 8; i++) run(tbl[i]);

        // Reset in the middle of a refill clears everything at once.
        icRE = 1'b1;
        icReadHit = 1'b0;
        icReadAddrIn = 32'h0000_3008;
        tick;
        icRE = 1'b0;
        memReqReady = 1'b1;
        tick;
        memReqReady = 1'b0;
        memRespValid = 1'b1;
        memRespData = 32'h5555_AAAA;
        tick;
        memRespValid = 1'b0;
        chk("mid_wait_busy", missBusy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req_valid", memReqValid, 1'b0);
        chk("arst_req_addr", memReqAddr, 32'h0);
        chk("arst_fill_we", fillWE, 1'b0);
        chk("arst_fill_addr", fillAddr, 32'h0);
        chk("arst_fill_data", fillData, 128'h0);
        chk("arst_busy", missBusy, 1'b0);
        exp_cnt = 0;
`ifdef ICACHE_MISS_PERF_COUNTER_EN
        chk("arst_count", missCount, 32'h0);
`endif
        tick;
        rst = 1'b1;
        tick;
        chk("post_rst_busy", missBusy, 1'b0);

        for (int n = 0; n < 40; n++) begin
            vec_t v;
            int sel;
            v.addr = $urandom;
            v.d = int'($urandom_range(0, 4));
            v.g0 = int'($urandom_range(1, 3));
            v.g = int'($urandom_range(0, 2));
            sel = int'($urandom_range(0, 5));
            v.fmode = (sel < 3) ? 0 : ((sel == 3) ? 1 : 2);
            v.fr = int'($urandom_range(0, v.d));
            v.fb = int'($urandom_range(0, 3));
            v.mw = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) v.beats[k] = $urandom;
            run(model(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_miss_ctrl.md
Name: icache_miss_ctrl

Overview:
Sequences I-cache line refills for the fetch stage.
- Detects a fetch miss from the I-cache read port and issues a single line-aligned request to the memory side.
- Collects the returned beats into a line buffer and writes the full line into the I-cache array in one cycle.
- Stalls fetch while a refill is in flight. Sits between FetchStage/ICache and the memory access arbiter.

Parameters:
ADDR_WIDTH, 32, physical address width (matches PhyAddrPath)
LINE_BYTES, 16, I-cache line size in bytes (power of two)
BEAT_WIDTH, 32, memory response beat width in bits; BEATS = LINE_BYTES*8/BEAT_WIDTH (default 4, must be >=1 and a power of two)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
icRE  in  1  fetch read enable this cycle
icReadHit  in  1  lane-0 hit for the current read
icReadAddrIn  in  ADDR_WIDTH  head fetch address
flush  in  1  pipeline redirect/flush; cancels the miss
memReqValid  out  1  line request valid
memReqReady  in  1  memory accepts request
memReqAddr  out  ADDR_WIDTH  line-aligned request address (low log2(LINE_BYTES) bits zero)
memRespValid  in  1  response beat valid; beats return in order, no backpressure
memRespData  in  BEAT_WIDTH  response beat
fillWE  out  1  I-cache array line write enable
fillAddr  out  ADDR_WIDTH  line-aligned fill address
fillData  out  LINE_BYTES*8  assembled line; beat k occupies bits [k*BEAT_WIDTH +: BEAT_WIDTH]
missBusy  out  1  refill in progress; fetch must stall

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, beat counter=0, abort=0, line buffer=0. All outputs 0.
- States: IDLE, REQ, WAIT, WRITE. missBusy = (state != IDLE). All outputs are registered-state decodes with no combinational path from memRespData.
- IDLE:
  - If icRE && !icReadHit && !flush, latch icReadAddrIn with its low offset bits cleared, then go to REQ.
  - Otherwise stay in IDLE.
  - Responses arriving in IDLE are ignored; a simulation assertion flags them.
- REQ:
  - memReqValid=1 and memReqAddr=latched address, both held stable until accepted.
  - On memReqReady, go to WAIT with beat=0.
  - If flush arrives before or in the same cycle as memReqReady: flush wins, no request is counted as issued, go to IDLE.
- WAIT:
  - On each memRespValid, write memRespData into buffer slot [beat], then beat++.
  - On the beat==BEATS-1 handshake, go to WRITE and wrap beat to 0.
  - A flush in WAIT sets abort=1. The controller keeps draining all BEATS beats because the request is already outstanding.
- WRITE (one cycle):
  - fillWE = !abort; fillAddr = latched address; fillData = buffer.
  - Clear abort and go to IDLE.
  - Miss indications in WRITE are ignored; the fetch retries the read in IDLE.
- Latency: miss seen in cycle N → memReqValid in N+1. Ready in N+1 → first beat accepted no earlier than N+2. Last beat in cycle M → fillWE in M+1, missBusy low in M+2.
- Flush while already in IDLE, or flush in WRITE: no effect on a write already committed in WRITE with abort=0.
- Only one request is ever outstanding.

Optional Feature:
- Macro ICACHE_MISS_PERF_COUNTER_EN.
- When defined:
  - Adds output missCount (32 bits), reset to 0.
  - Increments by 1 on each fillWE pulse (completed, non-aborted refills only).
  - Wraps from 0xFFFFFFFF to 0.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

Test Plan:
- Miss at addr 0x0000_1234, ready immediately, 4 beats 0xA,0xB,0xC,0xD back-to-back → memReqAddr=0x0000_1230; one fillWE with fillAddr=0x0000_1230 and fillData=0x0000000D_0000000C_0000000B_0000000A; missBusy high for exactly 7 cycles.
- memReqReady held low 5 cycles → memReqValid and memReqAddr stable all 5 cycles; no beats accepted before ready.
- Flush in WAIT after beat 1 → remaining 3 beats drained, fillWE stays 0, missBusy drops 2 cycles after the last beat.
- Flush in REQ with ready low → IDLE next cycle, no memory handshake occurs; a new miss at 0x40 then requests 0x40.
- Gapped beats (valid every 3rd cycle) plus icRE miss asserted during WRITE → correct line assembled, only one request issued; reset asserted mid-WAIT → all outputs 0 asynchronously.
- With ICACHE_MISS_PERF_COUNTER_EN: 3 completed refills plus 1 aborted refill → missCount=3.
